multicycle_controller: RTL and testbench

- Control unit for the multicycle MIPS processor, which replaces the single-cycle core.
- Moore FSM that sequences one shared ALU, one unified instruction/data memory, the IR and the register file over 3-5 cycles per instruction.
- Sits beside the datapath inside top. Takes op/funct from the IR and zero from the ALU, and drives every mux select and write enable.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/aludec.sv | 29 ++
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, functs, ALU codes, controller states and mux selects.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SEL_W    = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] ALUSRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] ALUSRCB_IMMSH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps aluop and funct to the ALU control code.
module aludec
  import mips_pkg::*;
(
  input  logic [ALUOP_W-1:0]  aluop,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath.
// Define BNE_EN to add the bne instruction (BNEEX state).
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [SEL_W-1:0]    alusrcb,
  output logic [SEL_W-1:0]    pcsrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                pcen,
  output logic [STATE_W-1:0]  state
);

  state_t             state_q;
  state_t             state_n;
  state_t             out_state;
  logic [ALUOP_W-1:0] aluop;
  logic               pcwrite;
  logic               branch;
  logic               bne;
  logic               irwrite_raw;
  logic               regwrite_raw;
  logic               memwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state_q)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTYPEEX;
          OP_BEQ:       state_n = S_BEQEX;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JEX;
`ifdef BNE_EN
          OP_BNE:       state_n = S_BNEEX;
`endif
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR:  state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_n = S_MEMWB;
      S_RTYPEEX: state_n = S_RTYPEWB;
      S_ADDIEX:  state_n = S_ADDIWB;
      default:   state_n = S_FETCH;
    endcase
  end

  // While reset is held the decode shows FETCH; write enables are gated below.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = ALUSRCB_B;
    pcsrc        = PCSRC_ALURESULT;
    aluop        = ALUOP_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne          = 1'b0;
    case (out_state)
      S_FETCH: begin
        alusrcb     = ALUSRCB_FOUR;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      S_DECODE: alusrcb = ALUSRCB_IMMSH2;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
`ifdef BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        bne     = 1'b1;
      end
`endif
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign irwrite  = irwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;

`ifdef BNE_EN
  assign pcen = (pcwrite | (branch & zero) | (bne & ~zero)) & ~reset;
`else
  assign pcen = (pcwrite | (branch & zero)) & ~reset;
  logic unused_bne;
  assign unused_bne = bne;
`endif

  assign state = STATE_W'(state_q);

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (honours BNE_EN when defined).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] rfun [5];
  logic [2:0] rctl [5];

  initial begin
    rfun[0] = 6'b100000; rctl[0] = 3'b010;
    rfun[1] = 6'b100010; rctl[1] = 3'b110;
    rfun[2] = 6'b100100; rctl[2] = 3'b000;
    rfun[3] = 6'b100101; rctl[3] = 3'b001;
    rfun[4] = 6'b101010; rctl[4] = 3'b111;

    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    tick();
    tick();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_pcen", 8'(pcen), 8'd0);
    chk("rst_regwrite", 8'(regwrite), 8'd0);
    chk("rst_memwrite", 8'(memwrite), 8'd0);
    chk("rst_irwrite", 8'(irwrite), 8'd0);
    chk("rst_alusrcb", 8'(alusrcb), 8'd1);
    reset = 1'b0;
    #1;
    chk("fetch_state", 8'(state), 8'd0);
    chk("fetch_irwrite", 8'(irwrite), 8'd1);
    chk("fetch_pcen", 8'(pcen), 8'd1);
    chk("fetch_alusrcb", 8'(alusrcb), 8'd1);
    chk("fetch_aluctl", 8'(alucontrol), 8'b010);

    // lw
    tick();
    chk("lw_decode", 8'(state), 8'd1);
    chk("lw_decode_alusrcb", 8'(alusrcb), 8'd3);
    chk("lw_decode_pcen", 8'(pcen), 8'd0);
    tick();
    chk("lw_memadr", 8'(state), 8'd2);
    chk("lw_memadr_srca", 8'(alusrca), 8'd1);
    chk("lw_memadr_srcb", 8'(alusrcb), 8'd2);
    chk("lw_memadr_iord", 8'(iord), 8'd0);
    tick();
    chk("lw_memrd", 8'(state), 8'd3);
    chk("lw_memrd_iord", 8'(iord), 8'd1);
    chk("lw_memrd_regwrite", 8'(regwrite), 8'd0);
    tick();
    chk("lw_memwb", 8'(state), 8'd4);
    chk("lw_memwb_memtoreg", 8'(memtoreg), 8'd1);
    chk("lw_memwb_regwrite", 8'(regwrite), 8'd1);
    chk("lw_memwb_regdst", 8'(regdst), 8'd0);
    chk("lw_memwb_iord", 8'(iord), 8'd0);
    tick();
    chk("lw_done", 8'(state), 8'd0);

    // sw
    op = 6'b101011;
    tick();
    chk("sw_decode", 8'(state), 8'd1);
    tick();
    chk("sw_memadr", 8'(state), 8'd2);
    chk("sw_memadr_memwrite", 8'(memwrite), 8'd0);
    tick();
    chk("sw_memwr", 8'(state), 8'd5);
    chk("sw_memwr_memwrite", 8'(memwrite), 8'd1);
    chk("sw_memwr_iord", 8'(iord), 8'd1);
    chk("sw_memwr_regwrite", 8'(regwrite), 8'd0);
    tick();
    chk("sw_done", 8'(state), 8'd0);
    chk("sw_done_memwrite", 8'(memwrite), 8'd0);

    // beq taken and not taken
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = 1'(z);
      tick();
      chk("beq_decode", 8'(state), 8'd1);
      tick();
      chk("beq_ex", 8'(state), 8'd8);
      chk("beq_pcen", 8'(pcen), 8'(z));
      chk("beq_pcsrc", 8'(pcsrc), 8'd1);
      chk("beq_aluctl", 8'(alucontrol), 8'b110);
      chk("beq_srca", 8'(alusrca), 8'd1);
      tick();
      chk("beq_done", 8'(state), 8'd0);
    end
    zero = 1'b0;

    // R-type over the five functs
    op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = rfun[i];
      tick();
      tick();
      chk("rtype_ex", 8'(state), 8'd6);
      chk("rtype_aluctl", 8'(alucontrol), 8'(rctl[i]));
      chk("rtype_ex_regwrite", 8'(regwrite), 8'd0);
      tick();
      chk("rtype_wb", 8'(state), 8'd7);
      chk("rtype_wb_regdst", 8'(regdst), 8'd1);
      chk("rtype_wb_regwrite", 8'(regwrite), 8'd1);
      tick();
      chk("rtype_done", 8'(state), 8'd0);
    end
    funct = 6'b111111;
    chk("fetch_funct_ignored", 8'(alucontrol), 8'b010);

    // addi
    op = 6'b001000;
    tick();
    tick();
    chk("addi_ex", 8'(state), 8'd9);
    chk("addi_ex_srcb", 8'(alusrcb), 8'd2);
    tick();
    chk("addi_wb", 8'(state), 8'd10);
    chk("addi_wb_regwrite", 8'(regwrite), 8'd1);
    chk("addi_wb_regdst", 8'(regdst), 8'd0);
    tick();
    chk("addi_done", 8'(state), 8'd0);

    // j
    op = 6'b000010;
    tick();
    tick();
    chk("j_ex", 8'(state), 8'd11);
    chk("j_pcsrc", 8'(pcsrc), 8'd2);
    chk("j_pcen", 8'(pcen), 8'd1);
    tick();
    chk("j_done", 8'(state), 8'd0);

    // reset while an sw sits in MEMADR
    op = 6'b101011;
    tick();
    tick();
    chk("swr_memadr", 8'(state), 8'd2);
    reset = 1'b1;
    #1;
    chk("swr_memwrite_rst", 8'(memwrite), 8'd0);
    chk("swr_pcen_rst", 8'(pcen), 8'd0);
    tick();
    chk("swr_state", 8'(state), 8'd0);
    chk("swr_memwrite_after", 8'(memwrite), 8'd0);
    reset = 1'b0;
    op = 6'b111111;
    #1;
    chk("swr_fetch_irwrite", 8'(irwrite), 8'd1);

    // illegal opcode behaves as a NOP
    tick();
    chk("ill_decode", 8'(state), 8'd1);
    chk("ill_regwrite", 8'(regwrite), 8'd0);
    chk("ill_memwrite", 8'(memwrite), 8'd0);
    chk("ill_pcen", 8'(pcen), 8'd0);
    tick();
    chk("ill_done", 8'(state), 8'd0);

    // bne opcode
    op = 6'b000101;
    zero = 1'b0;
    tick();
    tick();
`ifdef BNE_EN
    chk("bne_ex", 8'(state), 8'd12);
    chk("bne_pcen", 8'(pcen), 8'd1);
    chk("bne_pcsrc", 8'(pcsrc), 8'd1);
    zero = 1'b1;
    #1;
    chk("bne_pcen_zero", 8'(pcen), 8'd0);
    tick();
    chk("bne_done", 8'(state), 8'd0);
`else
    chk("bne_illegal", 8'(state), 8'd0);
    chk("bne_illegal_irwrite", 8'(irwrite), 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
